// File: rtl/pwm_sine_multi_if.sv
// Byte-stream link between the UART RX/TX pair and the sine PWM core.
// master = UART side, slave = core side.
interface pwm_sine_multi_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_valid
  );
endinterface

// File: rtl/pwm_sine_multi.sv
// Multi-channel DDS sine PWM with 3-byte frame configuration port.
// Each channel: phase accumulator -> quarter-wave LUT -> amplitude -> PWM.
module pwm_sine_multi #(
  parameter int CHANNELS       = 2,
  parameter int PWM_BITS       = 8,
  parameter int PHASE_BITS     = 16,
  parameter int LUT_ADDR_BITS  = 6,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                clk1,
  input  logic                rst,
  input  logic                en,
  pwm_sine_multi_if.slave     bus,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick
);

  localparam int LN = 2 ** LUT_ADDR_BITS;
  localparam int LW = PWM_BITS - 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PWM_BITS-1:0] MID =
    {1'b1, {(PWM_BITS-1){1'b0}}};
  localparam logic [PWM_BITS-1:0] CMAX = '1;

  // Integer Taylor series, 2^28 fixed point, so the table is
  // built at elaboration without real arithmetic.
  function automatic int lut_val(input int i);
    longint sc, hp, x, term, sum, amp;
    sc   = 64'sd268435456;
    hp   = 64'sd421657428;
    x    = hp * longint'(i) / longint'(LN);
    sum  = x;
    term = x;
    for (int k = 1; k < 8; k++) begin
      term = term * x / sc;
      term = term * x / sc;
      term = -term / longint'(2 * k * (2 * k + 1));
      sum  = sum + term;
    end
    amp = (64'sd1 <<< (PWM_BITS - 1)) - 64'sd1;
    return int'((amp * sum + sc / 2) / sc);
  endfunction

  logic [LW-1:0] lut [LN];

  for (genvar i = 0; i < LN; i++) begin : g_lut
    localparam int V = lut_val(i);
    assign lut[i] = LW'(V);
  end

  typedef enum logic [1:0] {
    IDLE, B1, B2, RESP
  } st_t;

  st_t            st_q, st_d;
  logic [1:0]     op_q, op_d;
  logic [3:0]     ch_q, ch_d;
  logic [7:0]     hi_q, hi_d;
  logic [7:0]     txd_q, txd_d;
  logic           ovr_q, ovr_d;
  logic [TW-1:0]  to_q, to_d;
  logic           wr_ftw, wr_amp;
  logic           expire, ch_ok;
  logic [PHASE_BITS-1:0] ftw_val;

  logic [PWM_BITS-1:0]   cnt_q;
  logic                  tick_q;
  logic [CHANNELS-1:0]   pwm_q;
  logic                  wrap;
  logic [PHASE_BITS-1:0] phase_q  [CHANNELS];
  logic [PHASE_BITS-1:0] ftw_q    [CHANNELS];
  logic [PHASE_BITS-1:0] ftw_sh_q [CHANNELS];
  logic [7:0]            amp_q    [CHANNELS];
  logic [7:0]            amp_sh_q [CHANNELS];
  logic [PWM_BITS-1:0]   duty_q   [CHANNELS];
  logic [PWM_BITS-1:0]   dnext_q  [CHANNELS];
  logic [PWM_BITS-1:0]   dnext_d  [CHANNELS];

  assign wrap        = en && (cnt_q == CMAX);
  assign pwm_out     = pwm_q;
  assign period_tick = tick_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [1:0]               q;
    logic [LUT_ADDR_BITS-1:0] a, idx;
    logic [LW+7:0]            prod;
    logic [LW-1:0]            s;

    assign q    = phase_q[c][PHASE_BITS-1 -: 2];
    assign a    = phase_q[c][PHASE_BITS-3 -: LUT_ADDR_BITS];
    assign idx  = q[0] ? ~a : a;
    assign prod = {8'd0, lut[idx]} * {{LW{1'b0}}, amp_q[c]};
    assign s    = prod[LW+7:8];
    assign dnext_d[c] = q[1] ? MID - {1'b0, s}
                             : MID + {1'b0, s};
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      pwm_q  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        phase_q[c]  <= '0;
        ftw_q[c]    <= '0;
        ftw_sh_q[c] <= '0;
        amp_q[c]    <= '0;
        amp_sh_q[c] <= '0;
        duty_q[c]   <= MID;
        dnext_q[c]  <= MID;
      end
    end else begin
      tick_q <= wrap;
      if (en) cnt_q <= cnt_q + 1'b1;
      for (int c = 0; c < CHANNELS; c++) begin
        dnext_q[c] <= dnext_d[c];
        pwm_q[c]   <= en && (cnt_q < duty_q[c]);
        if (wrap) begin
          duty_q[c]  <= dnext_q[c];
          phase_q[c] <= phase_q[c] + ftw_q[c];
          ftw_q[c]   <= ftw_sh_q[c];
          amp_q[c]   <= amp_sh_q[c];
        end
        if (wr_ftw && ch_q == 4'(c)) ftw_sh_q[c] <= ftw_val;
        if (wr_amp && ch_q == 4'(c)) amp_sh_q[c] <= bus.rx_data;
      end
    end
  end

  assign expire  = (to_q == TW'(TIMEOUT_CYCLES - 1));
  assign ch_ok   = {1'b0, ch_q} < 5'(CHANNELS);
  assign ftw_val = PHASE_BITS'({hi_q, bus.rx_data});

  assign bus.tx_valid = (st_q == RESP);
  assign bus.tx_data  = txd_q;

  always_comb begin
    st_d   = st_q;
    op_d   = op_q;
    ch_d   = ch_q;
    hi_d   = hi_q;
    txd_d  = txd_q;
    ovr_d  = ovr_q;
    to_d   = to_q;
    wr_ftw = 1'b0;
    wr_amp = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (bus.rx_valid) begin
          op_d = bus.rx_data[7:6];
          ch_d = bus.rx_data[3:0];
          to_d = '0;
          st_d = B1;
        end
      end
      B1, B2: begin
        if (expire) begin
          // a byte landing on expiry starts a fresh frame
          to_d = '0;
          if (bus.rx_valid) begin
            op_d = bus.rx_data[7:6];
            ch_d = bus.rx_data[3:0];
            st_d = B1;
          end else begin
            st_d = IDLE;
          end
        end else if (bus.rx_valid) begin
          to_d = '0;
          if (st_q == B1) begin
            hi_d = bus.rx_data;
            st_d = B2;
          end else begin
            st_d = RESP;
            unique case (op_q)
              2'b00: begin
                wr_ftw = ch_ok;
                txd_d  = ch_ok ? 8'hA5 : 8'hEE;
              end
              2'b01: begin
                wr_amp = ch_ok;
                txd_d  = ch_ok ? 8'hA5 : 8'hEE;
              end
              2'b10: begin
                txd_d = {ovr_q, 3'b000, 4'(CHANNELS - 1)};
                ovr_d = 1'b0;
              end
              default: txd_d = 8'hEE;
            endcase
          end
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      RESP: begin
        if (bus.rx_valid) ovr_d = 1'b1;
        if (bus.tx_ready) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      st_q  <= IDLE;
      op_q  <= '0;
      ch_q  <= '0;
      hi_q  <= '0;
      txd_q <= '0;
      ovr_q <= 1'b0;
      to_q  <= '0;
    end else begin
      st_q  <= st_d;
      op_q  <= op_d;
      ch_q  <= ch_d;
      hi_q  <= hi_d;
      txd_q <= txd_d;
      ovr_q <= ovr_d;
      to_q  <= to_d;
    end
  end

endmodule

// File: tb/tb_pwm_sine_multi.sv
// Directed bench for pwm_sine_multi: frame table plus
// hand-built sequences for duty, timeout, backpressure and reset.
module tb_pwm_sine_multi;

  localparam int CH = 2;

  logic          clk1 = 1'b0;
  logic          rst  = 1'b1;
  logic          en   = 1'b0;
  logic [CH-1:0] pwm_out;
  logic          period_tick;

  pwm_sine_multi_if bus();

  pwm_sine_multi #(
    .CHANNELS(2), .PWM_BITS(8), .PHASE_BITS(16),
    .LUT_ADDR_BITS(6), .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk1(clk1), .rst(rst), .en(en), .bus(bus),
    .pwm_out(pwm_out), .period_tick(period_tick)
  );

  always #5 clk1 = ~clk1;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] b0, b1, b2, rsp;
  } vec_t;

  vec_t vecs [6];
  int   hi0 [8];
  int   hi1 [8];
  int   pat [4];
  logic tx_seen;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk1);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk1);
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_resp(input logic [7:0] exp, input string nm);
    for (int i = 0; i < 50 && !bus.tx_valid; i++) @(negedge clk1);
    if (!bus.tx_valid) begin
      chk({nm, "_timeout"}, 0, 1);
    end else begin
      chk(nm, bus.tx_data, exp);
    end
  endtask

  task automatic frame(input logic [7:0] b0, b1, b2, exp,
                       input string nm);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    wait_resp(exp, nm);
  endtask

  task automatic wait_tick();
    int i;
    for (i = 0; i < 600 && !period_tick; i++) @(negedge clk1);
    if (!period_tick) chk("tick_wait", 0, 1);
  endtask

  // high-time per PWM period, aligned to period_tick
  task automatic measure(input int n);
    int c0, c1, tk;
    tx_seen = 1'b0;
    wait_tick();
    for (int p = 0; p < n; p++) begin
      c0 = 0; c1 = 0; tk = 0;
      for (int j = 0; j < 256; j++) begin
        @(negedge clk1);
        c0 += int'(pwm_out[0]);
        c1 += int'(pwm_out[1]);
        tk += int'(period_tick);
        if (bus.tx_valid) tx_seen = 1'b1;
      end
      chk("tick_count", tk, 1);
      chk("tick_at_end", period_tick, 1);
      hi0[p] = c0;
      hi1[p] = c1;
    end
  endtask

  initial begin
    int o, seen, tk;
    vecs[0] = '{8'h01, 8'h40, 8'h00, 8'hA5};
    vecs[1] = '{8'h41, 8'h00, 8'hFF, 8'hA5};
    vecs[2] = '{8'h05, 8'h12, 8'h34, 8'hEE};
    vecs[3] = '{8'hC0, 8'h00, 8'h00, 8'hEE};
    vecs[4] = '{8'h80, 8'h00, 8'h00, 8'h01};
    vecs[5] = '{8'h42, 8'h00, 8'h10, 8'hEE};
    pat = '{128, 254, 128, 2};

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk1);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_tick", period_tick, 0);
    chk("rst_txv", bus.tx_valid, 0);
    chk("rst_txd", bus.tx_data, 0);
    rst = 1'b0;
    en  = 1'b1;

    measure(2);
    for (int p = 0; p < 2; p++) begin
      chk("idle_ch0", hi0[p], 128);
      chk("idle_ch1", hi1[p], 128);
    end
    chk("idle_no_tx", tx_seen, 0);

    for (int v = 0; v < 6; v++)
      frame(vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].rsp,
            $sformatf("vec%0d", v));

    repeat (600) @(negedge clk1);
    measure(8);
    if (hi1[0] == 254) o = 1;
    else if (hi1[0] == 2) o = 3;
    else if (hi1[1] == 254) o = 0;
    else o = 2;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ch1_duty%0d", i), hi1[i], pat[(o + i) % 4]);
      chk($sformatf("ch0_duty%0d", i), hi0[i], 128);
    end

    en = 1'b0;
    repeat (3) @(negedge clk1);
    chk("en0_pwm", pwm_out, 0);
    tk = 0;
    repeat (300) begin
      @(negedge clk1);
      tk += int'(period_tick);
    end
    chk("en0_no_tick", tk, 0);
    en = 1'b1;

    send_byte(8'h00);
    seen = 0;
    repeat (1001) begin
      @(negedge clk1);
      if (bus.tx_valid) seen = 1;
    end
    chk("partial_no_resp", seen, 0);
    frame(8'h00, 8'h40, 8'h00, 8'hA5, "after_timeout");
    seen = 0;
    repeat (30) begin
      @(negedge clk1);
      if (bus.tx_valid) seen = 1;
    end
    chk("single_resp", seen, 0);

    bus.tx_ready = 1'b0;
    frame(8'h41, 8'h00, 8'hFF, 8'hA5, "bp_resp");
    send_byte(8'h77);
    repeat (4) @(negedge clk1);
    chk("bp_hold_v", bus.tx_valid, 1);
    chk("bp_hold_d", bus.tx_data, 8'hA5);
    bus.tx_ready = 1'b1;
    @(negedge clk1);
    chk("bp_release", bus.tx_valid, 0);
    frame(8'h80, 8'h00, 8'h00, 8'h81, "status_ovr");
    frame(8'h80, 8'h00, 8'h00, 8'h01, "status_clr");

    wait_tick();
    send_byte(8'h01);
    repeat (98) @(negedge clk1);
    chk("pre_rst_pwm0", pwm_out[0], 1);
    #2 rst = 1'b1;
    #1;
    chk("async_pwm", pwm_out, 0);
    chk("async_tick", period_tick, 0);
    chk("async_txv", bus.tx_valid, 0);
    chk("async_txd", bus.tx_data, 0);
    @(negedge clk1);
    rst = 1'b0;
    frame(8'h80, 8'h00, 8'h00, 8'h01, "post_rst_status");
    frame(8'h01, 8'h40, 8'h00, 8'hA5, "post_rst_ftw");
    measure(1);
    chk("post_rst_ch0", hi0[0], 128);
    chk("post_rst_ch1", hi1[0], 128);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
